// File: rtl/wave_capture_if.sv
// Sample-stream and sample-RAM write-port bundle for wave_capture.
// The master drives samples and display status; the slave (the capture block) drives RAM writes.
interface wave_capture_if #(
  parameter int ADDR_W = 8
);
  logic              new_sample_ready;
  logic [15:0]       new_sample_in;
  logic              wave_display_idle;
  logic [ADDR_W:0]   write_address;
  logic              write_enable;
  logic [7:0]        write_sample;
  logic              read_index;

  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// Captures one zero-crossing-triggered window of samples into the write half of a double-buffered RAM.
// Optional WAVE_CAPTURE_DECIMATE_EN: keep only every second sample after the trigger.
module wave_capture #(
  parameter int NUM_SAMPLES = 256,
  parameter int ADDR_W      = 8
) (
  input  logic           clk,
  input  logic           reset,
  wave_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  function automatic logic [7:0] to_offset_binary(input logic [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_index;
  logic [ADDR_W-1:0]   w_index_next;
  logic [ADDR_W-1:0]   w_wr_index;
  logic                r_prev_neg;
  logic                r_read_index;
  logic                w_read_index_next;
  logic                r_write_enable;
  logic [ADDR_W:0]     r_write_address;
  logic [7:0]          r_write_sample;
  logic                w_trigger;
  logic                w_accept;
  logic                w_last;
  logic                w_unused;

  assign w_trigger = bus.new_sample_ready && r_prev_neg && !bus.new_sample_in[15];
  assign w_last    = (r_index == ADDR_W'(NUM_SAMPLES - 1));
  assign w_unused  = ^bus.new_sample_in[7:0];

`ifdef WAVE_CAPTURE_DECIMATE_EN
  logic r_phase;
  logic w_phase_next;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ARMED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ARMED: begin
        if (w_trigger) begin
          w_state_next = ST_ACTIVE;
        end else begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ACTIVE: begin
        if (w_accept && w_last) begin
          w_state_next = ST_WAIT;
        end else begin
          w_state_next = ST_ACTIVE;
        end
      end
      ST_WAIT: begin
        if (bus.wave_display_idle) begin
          w_state_next = ST_ARMED;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      default: w_state_next = ST_ARMED;
    endcase
  end

  // Write acceptance, index advance and buffer swap
  always_comb begin
    w_accept          = 1'b0;
    w_wr_index        = r_index;
    w_index_next      = r_index;
    w_read_index_next = r_read_index;
`ifdef WAVE_CAPTURE_DECIMATE_EN
    w_phase_next      = r_phase;
`endif
    case (r_state)
      ST_ARMED: begin
        if (w_trigger) begin
          w_accept     = 1'b1;
          w_wr_index   = '0;
          w_index_next = ADDR_W'(1);
`ifdef WAVE_CAPTURE_DECIMATE_EN
          w_phase_next = 1'b0;
`endif
        end else begin
          w_accept = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (bus.new_sample_ready) begin
`ifdef WAVE_CAPTURE_DECIMATE_EN
          w_phase_next = ~r_phase;
          w_accept     = r_phase;
`else
          w_accept     = 1'b1;
`endif
        end else begin
          w_accept = 1'b0;
        end
        // Index is ADDR_W wide, so incrementing past NUM_SAMPLES-1 wraps to 0
        if (w_accept) begin
          w_index_next = r_index + ADDR_W'(1);
        end else begin
          w_index_next = r_index;
        end
      end
      ST_WAIT: begin
        if (bus.wave_display_idle) begin
          w_read_index_next = ~r_read_index;
        end else begin
          w_read_index_next = r_read_index;
        end
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index         <= '0;
      r_prev_neg      <= 1'b0;
      r_read_index    <= 1'b0;
      r_write_enable  <= 1'b0;
      r_write_address <= '0;
      r_write_sample  <= 8'h00;
    end else begin
      r_index        <= w_index_next;
      r_read_index   <= w_read_index_next;
      r_write_enable <= w_accept;
      if (bus.new_sample_ready) begin
        r_prev_neg <= bus.new_sample_in[15];
      end
      if (w_accept) begin
        r_write_address <= {~r_read_index, w_wr_index};
        r_write_sample  <= to_offset_binary(bus.new_sample_in);
      end
    end
  end

`ifdef WAVE_CAPTURE_DECIMATE_EN
  // Decimation phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= w_phase_next;
    end
  end
`endif

  assign bus.write_enable  = r_write_enable;
  assign bus.write_address = r_write_address;
  assign bus.write_sample  = r_write_sample;
  assign bus.read_index    = r_read_index;

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Captures one triggered window of audio samples from the music player into the write half of the wave display's double-buffered sample RAM.
- Arms, waits for a positive-going zero crossing, then writes NUM_SAMPLES consecutive samples as 8-bit offset-binary values.
- After the window is written, waits for the display to go idle, swaps buffer halves, and re-arms.
- Sits between music_player (sample_out / new_sample_generated) and the wave display's RAM write port.

Parameters:
- NUM_SAMPLES, 256, samples per captured window; power of two.
- ADDR_W, 8, log2(NUM_SAMPLES); width of the in-buffer index.

Ports:
- clk  input  1  system clock (clk_100 domain).
- reset  input  1  asynchronous, active-low reset.
- new_sample_ready  input  1  single-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  16  signed two's-complement audio sample.
- wave_display_idle  input  1  high while the display is not reading the sample RAM (vertical blanking).
- write_address  output  ADDR_W+1  RAM write address: {~read_index, index}.
- write_enable  output  1  single-cycle RAM write strobe.
- write_sample  output  8  offset-binary sample: {~new_sample_in[15], new_sample_in[14:8]}.
- read_index  output  1  buffer half the display reads; the capture writes the other half.

Behaviour:
- All outputs are registered.
- Reset (reset low, asynchronous):
  - state = ARMED; index = 0; prev_neg = 0.
  - read_index = 0; write_enable = 0; write_address = 0; write_sample = 0.
- prev_neg tracking: on every new_sample_ready, in every state, prev_neg <= new_sample_in[15].
- Trigger: new_sample_ready && prev_neg && !new_sample_in[15].
  - The previous sample was negative and the current one is >= 0.
  - A sample of 0 counts as non-negative.
- States:
  - ARMED
    - On trigger: write the current sample at index 0, set index = 1, go to ACTIVE.
    - No trigger: no writes.
  - ACTIVE
    - On new_sample_ready: write at the current index, then index increments.
    - If the written index == NUM_SAMPLES-1: index wraps to 0 and state goes to WAIT.
  - WAIT
    - Samples are ignored; prev_neg still updates.
    - On wave_display_idle == 1: read_index toggles, state goes to ARMED.
- Write timing:
  - write_enable pulses exactly one cycle, in the cycle after the accepted new_sample_ready.
  - write_address and write_sample are valid in that same cycle.
  - Latency is 1 clock.
- Address: write_address = {~read_index, index}, using read_index as it stands before any toggle. A capture therefore never writes the half the display is reading.
- wave_display_idle is ignored in ARMED and ACTIVE.
- Simultaneous wave_display_idle and new_sample_ready in WAIT:
  - The swap occurs and the sample updates prev_neg.
  - The sample is not evaluated as a trigger, since the trigger is checked only in ARMED.
  - A crossing can trigger no earlier than the next sample.
- Back-to-back new_sample_ready on consecutive cycles is legal; each produces its own write.
- Reset mid-ACTIVE: the capture aborts, the partial buffer is left as-is (stale), and read_index returns to 0.
- No internal limit on time spent in ARMED; silence (all samples >= 0) keeps the block ARMED indefinitely.

Optional Feature:
- Macro: WAVE_CAPTURE_DECIMATE_EN.
- Defined:
  - ACTIVE accepts every second new_sample_ready, so a window spans 2*NUM_SAMPLES input samples.
  - A 1-bit phase toggles on each new_sample_ready in ACTIVE; writes occur only when phase == 1.
  - The trigger sample in ARMED is always written at index 0, and phase clears to 0 at the trigger.
  - Trigger detection and prev_neg are unchanged.
- Undefined: every sample is accepted in ACTIVE; no phase register exists.

Test Plan:
- Reset release, then samples 0x0100, 0x0200 (no negative sample first) -> no write_enable; state stays ARMED; read_index = 0.
- Samples 0xFF00 then 0x0010 -> write_enable one cycle after the second strobe with write_address = 0x100, write_sample = 0x80.
- After the trigger, 255 further samples of value 0x7FFF:
  - Writes to addresses 0x101..0x1FF, each with write_sample = 0xFF.
  - Afterwards, extra strobes produce no writes (WAIT).
- In WAIT, pulse wave_display_idle -> read_index = 1.
  - Next trigger pair 0x8000, 0x0000 writes address 0x000 with data 0x80.
- Assert reset low after 10 writes in ACTIVE -> all outputs 0 immediately (asynchronous); state ARMED; read_index = 0.
- With WAVE_CAPTURE_DECIMATE_EN: trigger, then 510 strobes -> exactly 255 further writes, on alternate strobes; the window completes on the 510th.
